// File: rtl/vram_arbiter.sv
// Single-port text VRAM arbiter: display fetch > clear engine > host write.
// Define CLEAR_ENGINE_EN to build the clear-screen engine; otherwise clr_* is inert.
module vram_arbiter #(
  parameter int DEPTH  = 3600,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_fill,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic              clr_wr;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] clr_wdata;
  logic              host_block;
  logic              host_wr;

`ifdef CLEAR_ENGINE_EN
  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clr_start) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
          fill_d  = clr_fill;
          busy_d  = 1'b1;
        end
      end
      S_CLEAR: begin
        // A display fetch owns the RAM this cycle, so the sweep stalls.
        if (!disp_req) begin
          if (cnt_q == LAST_ADDR) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    fill_q <= fill_d;
  end

  assign clr_wr     = (state_q == S_CLEAR);
  assign clr_addr   = cnt_q;
  assign clr_wdata  = fill_q;
  assign host_block = busy_q || (clr_start && (state_q == S_IDLE));
  assign clr_busy   = busy_q;
  assign clr_done   = done_q;
`else
  logic unused_clr;

  assign unused_clr = ^{clr_start, clr_fill};
  assign clr_wr     = 1'b0;
  assign clr_addr   = '0;
  assign clr_wdata  = '0;
  assign host_block = 1'b0;
  assign clr_busy   = 1'b0;
  assign clr_done   = 1'b0;
`endif

  assign host_ready = !disp_req && !host_block;
  // Out-of-range host writes complete the handshake but never reach the RAM.
  assign host_wr    = host_valid && host_ready && (host_addr <= LAST_ADDR);

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = disp_addr;
    ram_wdata = host_wdata;
    if (disp_req) begin
      ram_en   = 1'b1;
      ram_addr = disp_addr;
    end else if (clr_wr) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = clr_addr;
      ram_wdata = clr_wdata;
    end else if (host_wr) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = host_addr;
      ram_wdata = host_wdata;
    end
  end

  logic              vld_p1_q, vld_p1_d;
  logic              vld_p2_q, vld_p2_d;
  logic [DATA_W-1:0] rdata_p2_q, rdata_p2_d;

  always_comb begin
    vld_p1_d   = disp_req;
    vld_p2_d   = vld_p1_q;
    rdata_p2_d = vld_p1_q ? ram_rdata : rdata_p2_q;
  end

  // p1: RAM read in flight; p2: read data captured and presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      rdata_p2_q <= '0;
    end else begin
      vld_p1_q   <= vld_p1_d;
      vld_p2_q   <= vld_p2_d;
      rdata_p2_q <= rdata_p2_d;
    end
  end

  assign disp_rvalid = vld_p2_q;
  assign disp_rdata  = rdata_p2_q;

endmodule
